// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: standard mode
// timings, a packed mode descriptor and a clog2 helper for counter widths.
package vga_pkg;

  typedef struct packed {
    logic [11:0] active;
    logic [11:0] front;
    logic [11:0] sync;
    logic [11:0] back;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60 = '{
    h: '{active: 12'd640, front: 12'd16, sync: 12'd96,  back: 12'd48},
    v: '{active: 12'd480, front: 12'd10, sync: 12'd2,   back: 12'd33}
  };

  localparam vga_mode_t MODE_800X600_60 = '{
    h: '{active: 12'd800, front: 12'd40, sync: 12'd128, back: 12'd88},
    v: '{active: 12'd600, front: 12'd1,  sync: 12'd4,   back: 12'd23}
  };

  // Smallest r with 2**r >= n; used to size the h/v counters.
  function automatic int vga_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/vga_pix_ce_div.sv
// Pixel clock-enable divider: pix_ce is high for one system clock out of
// every CLK_DIV. With CLK_DIV=1 pix_ce is constantly high, including in reset.
module vga_pix_ce_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_ce
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;

  // Next divider value, wrapping after CLK_DIV-1.
  always_comb begin
    div_next = (div == LAST) ? '0 : div + 1'b1;
  end

  // Divider register; pix_ce is registered so it is high exactly while div == LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      pix_ce <= (CLK_DIV == 1);
    end else begin
      div    <= div_next;
      pix_ce <= (div_next == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Produces pix_ce, registered hsync/vsync of selectable polarity, de,
// active-area coordinates and line/frame strobes.
// Build option: define VGA_TIMING_SCROLL_EN to compile in the per-frame
// scroll latch and modulo adders; otherwise pix_x/pix_y are raw h/v and the
// scroll inputs are ignored.
//
// h/v hold the position of the pixel that the next pix_ce will present.
// On each pix_ce edge the outputs are loaded from h/v and the counters step,
// so outputs and the pixel they describe change on the same edge.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = int'(MODE_640X480_60.h.active),
  parameter int H_FRONT  = int'(MODE_640X480_60.h.front),
  parameter int H_SYNC   = int'(MODE_640X480_60.h.sync),
  parameter int H_BACK   = int'(MODE_640X480_60.h.back),
  parameter int V_ACTIVE = int'(MODE_640X480_60.v.active),
  parameter int V_FRONT  = int'(MODE_640X480_60.v.front),
  parameter int V_SYNC   = int'(MODE_640X480_60.v.sync),
  parameter int V_BACK   = int'(MODE_640X480_60.v.back),
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = vga_clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
  parameter int YW       = vga_clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] scroll_x,
  input  logic [YW-1:0] scroll_y,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

  // Region bounds are one bit wider so a boundary equal to 2**XW still fits.
  localparam logic [XW:0] H_ACT_W = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0] HS_BEG  = (XW+1)'(H_ACTIVE + H_FRONT);
  localparam logic [XW:0] HS_END  = (XW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YW:0] V_ACT_W = (YW+1)'(V_ACTIVE);
  localparam logic [YW:0] VS_BEG  = (YW+1)'(V_ACTIVE + V_FRONT);
  localparam logic [YW:0] VS_END  = (YW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  logic          ce;
  logic [XW-1:0] h;
  logic [XW-1:0] h_next;
  logic [YW-1:0] v;
  logic [YW-1:0] v_next;
  logic          h_end;
  logic          v_end;
  logic          de_next;
  logic          hs_on;
  logic          vs_on;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;

  vga_pix_ce_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (ce)
  );

  assign pix_ce = ce;

  // Raster step and region decode for the pixel about to be presented.
  always_comb begin
    h_end   = (h == H_LAST);
    v_end   = (v == V_LAST);
    h_next  = h_end ? '0 : h + 1'b1;
    v_next  = v;
    if (h_end) begin
      v_next = v_end ? '0 : v + 1'b1;
    end
    de_next = ({1'b0, h} < H_ACT_W) && ({1'b0, v} < V_ACT_W);
    hs_on   = ({1'b0, h} >= HS_BEG) && ({1'b0, h} < HS_END);
    vs_on   = ({1'b0, v} >= VS_BEG) && ({1'b0, v} < VS_END);
  end

`ifdef VGA_TIMING_SCROLL_EN
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;

  // Scroll offsets captured on the last pixel of a frame; out-of-range values load as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
    end else if (ce && h_end && v_end) begin
      sx <= ({1'b0, scroll_x} < H_ACT_W) ? scroll_x : '0;
      sy <= ({1'b0, scroll_y} < V_ACT_W) ? scroll_y : '0;
    end
  end

  // Wrap the scrolled position back into the active area with one subtraction.
  always_comb begin
    sum_x  = {1'b0, h} + {1'b0, sx};
    sum_y  = {1'b0, v} + {1'b0, sy};
    x_next = (sum_x >= H_ACT_W) ? XW'(sum_x - H_ACT_W) : XW'(sum_x);
    y_next = (sum_y >= V_ACT_W) ? YW'(sum_y - V_ACT_W) : YW'(sum_y);
  end
`else
  // Scroll inputs have no function in this build.
  logic unused_scroll;
  assign unused_scroll = ^{scroll_x, scroll_y};

  // Coordinates are the raw raster position.
  always_comb begin
    x_next = h;
    y_next = v;
  end
`endif

  // Counters and registered outputs, advanced once per pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      h           <= h_next;
      v           <= v_next;
      hsync       <= hs_on ? HS_POL : ~HS_POL;
      vsync       <= vs_on ? VS_POL : ~VS_POL;
      de          <= de_next;
      pix_x       <= de_next ? x_next : '0;
      pix_y       <= de_next ? y_next : '0;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule
